// File: rtl/instr_issue_queue_if.sv
// Bundle push / instruction pop interface of the instruction issue queue.
//   push_*  : control unit offers one bundle per push_valid && push_ready.
//   pop_*   : queue presents pop_count lanes; the consumer returns pop_accept.
// Modports: master = control unit / consumer side, slave = the queue.
interface instr_issue_queue_if #(
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int POP_WIDTH             = 3,
    parameter int ADDR_W                = 18
);
    logic                             push_valid;
    logic                             push_ready;
    logic [15:0]                      push_instr;
    logic [LOG_SUPERSCALAR_WIDTH:0]   push_copies;
    logic [ADDR_W-1:0]                push_cache_addr;
    logic [ADDR_W-1:0]                push_cache_stride;
    logic [ADDR_W-1:0]                push_main_mem_addr;
    logic [1:0]                       pop_count;
    logic [1:0]                       pop_accept;
    logic [16*POP_WIDTH-1:0]          pop_instr;
    logic [ADDR_W*POP_WIDTH-1:0]      pop_cache_addr;
    logic [ADDR_W*POP_WIDTH-1:0]      pop_main_mem_addr;

    modport master (
        output push_valid, push_instr, push_copies, push_cache_addr,
               push_cache_stride, push_main_mem_addr, pop_accept,
        input  push_ready, pop_count, pop_instr, pop_cache_addr, pop_main_mem_addr
    );

    modport slave (
        input  push_valid, push_instr, push_copies, push_cache_addr,
               push_cache_stride, push_main_mem_addr, pop_accept,
        output push_ready, pop_count, pop_instr, pop_cache_addr, pop_main_mem_addr
    );
endinterface

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers instruction bundles (one instruction plus a
// copy count and APU addresses) and expands each bundle into up to POP_WIDTH
// instructions per cycle, stepping the cache address by the bundle stride.
// Ports:
//   clk, reset_n (async active-low), flush (synchronous clear)
//   q         : instr_issue_queue_if.slave (push and pop handshakes)
//   occupancy : number of bundles held (0..2^LOG_DEPTH)
// Optional macro IIQ_STATS_EN adds stat_bundles, stat_issued, stat_push_stalls.
module instr_issue_queue #(
    parameter int LOG_DEPTH             = 4,
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int POP_WIDTH             = 3,
    parameter int ADDR_W                = 18
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    instr_issue_queue_if.slave   q,
    output logic [LOG_DEPTH:0]   occupancy
`ifdef IIQ_STATS_EN
    ,
    output logic [31:0]          stat_bundles,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_push_stalls
`endif
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW    = LOG_SUPERSCALAR_WIDTH + 1;
    localparam logic [CW-1:0]        MAX_COPIES = CW'(1 << LOG_SUPERSCALAR_WIDTH);
    localparam logic [LOG_DEPTH:0]   FULL_OCC   = (LOG_DEPTH+1)'(DEPTH);

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_ISSUING = 1'b1} state_t;

    // Copy counts outside 1..MAX_COPIES are clamped on the way in.
    function automatic logic [CW-1:0] sat_copies(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        if (c == '0) begin
            r = CW'(1);
        end else if (c > MAX_COPIES) begin
            r = MAX_COPIES;
        end else begin
            r = c;
        end
        return r;
    endfunction

    logic [15:0]        mem_instr_r  [DEPTH];
    logic [CW-1:0]      mem_copies_r [DEPTH];
    logic [ADDR_W-1:0]  mem_cache_r  [DEPTH];
    logic [ADDR_W-1:0]  mem_stride_r [DEPTH];
    logic [ADDR_W-1:0]  mem_main_r   [DEPTH];

    logic [LOG_DEPTH-1:0] wr_ptr_r, rd_ptr_r;
    logic [LOG_DEPTH:0]   occ_r;
    logic [CW-1:0]        head_off_r;
    state_t               state_r, state_next_s;

    logic [15:0]          head_instr_s;
    logic [CW-1:0]        head_copies_s, head_rem_s;
    logic [ADDR_W-1:0]    head_cache_s, head_stride_s, head_main_s;
    logic                 push_ready_s, push_fire_s, retire_s;
    logic [1:0]           pop_count_s, accept_s;
    logic [16*POP_WIDTH-1:0]     pop_instr_s;
    logic [ADDR_W*POP_WIDTH-1:0] pop_cache_s, pop_main_s;

    assign head_instr_s  = mem_instr_r[rd_ptr_r];
    assign head_copies_s = mem_copies_r[rd_ptr_r];
    assign head_cache_s  = mem_cache_r[rd_ptr_r];
    assign head_stride_s = mem_stride_r[rd_ptr_r];
    assign head_main_s   = mem_main_r[rd_ptr_r];

    // Handshake decode: push readiness ignores a same-cycle retire on purpose.
    always_comb begin
        push_ready_s = (occ_r != FULL_OCC) && !flush;
        push_fire_s  = q.push_valid && push_ready_s;
        head_rem_s   = head_copies_s - head_off_r;
        pop_count_s  = 2'd0;
        if (state_r == ST_ISSUING) begin
            if (head_rem_s > CW'(POP_WIDTH)) begin
                pop_count_s = 2'(POP_WIDTH);
            end else begin
                pop_count_s = head_rem_s[1:0];
            end
        end else begin
            pop_count_s = 2'd0;
        end
        // Accepting more lanes than offered is clipped, not propagated.
        if (q.pop_accept > pop_count_s) begin
            accept_s = pop_count_s;
        end else begin
            accept_s = q.pop_accept;
        end
        retire_s = (pop_count_s != 2'd0) &&
                   ((head_off_r + CW'(accept_s)) == head_copies_s);
    end

    // Lane expansion: lane k carries copy head_off+k of the head bundle.
    always_comb begin
        pop_instr_s = '0;
        pop_cache_s = '0;
        pop_main_s  = '0;
        for (int k = 0; k < POP_WIDTH; k++) begin
            if (k < int'(pop_count_s)) begin
                pop_instr_s[16*k +: 16]         = head_instr_s;
                pop_cache_s[ADDR_W*k +: ADDR_W] = head_cache_s +
                    (ADDR_W'(head_off_r) + ADDR_W'(k)) * head_stride_s;
                pop_main_s[ADDR_W*k +: ADDR_W]  = head_main_s;
            end else begin
                pop_instr_s[16*k +: 16]         = 16'd0;
                pop_cache_s[ADDR_W*k +: ADDR_W] = '0;
                pop_main_s[ADDR_W*k +: ADDR_W]  = '0;
            end
        end
    end

    // Head FSM next state: the queue stays ISSUING while any bundle remains.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_fire_s) begin
                    state_next_s = ST_ISSUING;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ISSUING: begin
                if (flush) begin
                    state_next_s = ST_EMPTY;
                end else if (retire_s && (occ_r == (LOG_DEPTH+1)'(1)) && !push_fire_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ISSUING;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Head FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pointer, occupancy and head offset bookkeeping; flush wins over traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            occ_r      <= '0;
            head_off_r <= '0;
        end else if (flush) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            occ_r      <= '0;
            head_off_r <= '0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + LOG_DEPTH'(1);
            end
            if (retire_s) begin
                rd_ptr_r   <= rd_ptr_r + LOG_DEPTH'(1);
                head_off_r <= '0;
            end else begin
                head_off_r <= head_off_r + CW'(accept_s);
            end
            occ_r <= occ_r + (LOG_DEPTH+1)'(push_fire_s) - (LOG_DEPTH+1)'(retire_s);
        end
    end

    // Bundle storage; contents need no reset since occupancy guards them.
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            mem_instr_r[wr_ptr_r]  <= q.push_instr;
            mem_copies_r[wr_ptr_r] <= sat_copies(q.push_copies);
            mem_cache_r[wr_ptr_r]  <= q.push_cache_addr;
            mem_stride_r[wr_ptr_r] <= q.push_cache_stride;
            mem_main_r[wr_ptr_r]   <= q.push_main_mem_addr;
        end
    end

`ifdef IIQ_STATS_EN
    // Statistics counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_bundles     <= 32'd0;
            stat_issued      <= 32'd0;
            stat_push_stalls <= 32'd0;
        end else if (flush) begin
            stat_bundles     <= 32'd0;
            stat_issued      <= 32'd0;
            stat_push_stalls <= 32'd0;
        end else begin
            stat_bundles     <= stat_bundles + 32'(push_fire_s);
            stat_issued      <= stat_issued + 32'(accept_s);
            stat_push_stalls <= stat_push_stalls + 32'(q.push_valid && !push_ready_s);
        end
    end
`endif

    assign q.push_ready        = push_ready_s;
    assign q.pop_count         = pop_count_s;
    assign q.pop_instr         = pop_instr_s;
    assign q.pop_cache_addr    = pop_cache_s;
    assign q.pop_main_mem_addr = pop_main_s;
    assign occupancy           = occ_r;
endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue: constant vector table for the
// basic expansion, hand sequences for corner cases, then random traffic
// compared against a queue-of-bundles reference model.
module tb_instr_issue_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [4:0]  occupancy;
`ifdef IIQ_STATS_EN
    logic [31:0] stat_bundles, stat_issued, stat_push_stalls;
    int          m_bundles, m_issued, m_stalls;
`endif

    instr_issue_queue_if #(.LOG_SUPERSCALAR_WIDTH(3), .POP_WIDTH(3), .ADDR_W(18)) q_if ();

    instr_issue_queue #(.LOG_DEPTH(4), .LOG_SUPERSCALAR_WIDTH(3), .POP_WIDTH(3), .ADDR_W(18)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .q         (q_if),
        .occupancy (occupancy)
`ifdef IIQ_STATS_EN
        ,
        .stat_bundles     (stat_bundles),
        .stat_issued      (stat_issued),
        .stat_push_stalls (stat_push_stalls)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        int          copies;
        int          ca;
        int          cs;
        int          mm;
    } bundle_t;
    bundle_t mq[$];
    int      m_off = 0;

    typedef struct {
        logic        v;
        logic [3:0]  cp;
        logic [17:0] ca;
        logic [17:0] cs;
        logic [1:0]  acc;
        logic [1:0]  e_pc;
        logic [53:0] e_cache;
        logic [4:0]  e_occ;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_pc();
        int r;
        if (mq.size() == 0) r = 0;
        else begin
            r = mq[0].copies - m_off;
            if (r > 3) r = 3;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic [3:0] cp,
                         input logic [17:0] ca, input logic [17:0] cs, input logic [17:0] mm,
                         input logic [1:0] acc, input logic fl);
        q_if.push_valid         = v;
        q_if.push_instr         = ins;
        q_if.push_copies        = cp;
        q_if.push_cache_addr    = ca;
        q_if.push_cache_stride  = cs;
        q_if.push_main_mem_addr = mm;
        q_if.pop_accept         = acc;
        flush                   = fl;
    endtask

    task automatic compare_model();
        logic [47:0] ei;
        logic [53:0] ec, em;
        int pc;
        pc = exp_pc();
        ei = '0; ec = '0; em = '0;
        for (int k = 0; k < 3; k++) begin
            if (k < pc) begin
                ei[16*k +: 16] = mq[0].instr;
                ec[18*k +: 18] = 18'(mq[0].ca + (m_off + k) * mq[0].cs);
                em[18*k +: 18] = 18'(mq[0].mm);
            end
        end
        check("pop_count", 64'(q_if.pop_count), 64'(pc));
        check("push_ready", 64'(q_if.push_ready), 64'((mq.size() != 16) && !flush));
        check("occupancy", 64'(occupancy), 64'(mq.size()));
        check("pop_instr", 64'(q_if.pop_instr), 64'(ei));
        check("pop_cache_addr", 64'(q_if.pop_cache_addr), 64'(ec));
        check("pop_main_mem_addr", 64'(q_if.pop_main_mem_addr), 64'(em));
`ifdef IIQ_STATS_EN
        check("stat_bundles", 64'(stat_bundles), 64'(m_bundles));
        check("stat_issued", 64'(stat_issued), 64'(m_issued));
        check("stat_push_stalls", 64'(stat_push_stalls), 64'(m_stalls));
`endif
    endtask

    task automatic model_clear();
        mq.delete();
        m_off = 0;
`ifdef IIQ_STATS_EN
        m_bundles = 0; m_issued = 0; m_stalls = 0;
`endif
    endtask

    // Apply one clock edge to the model using the inputs the bench is driving.
    task automatic advance();
        int pc, a, cp;
        logic ready;
        bundle_t b;
        @(posedge clk);
        pc = exp_pc();
        a  = (int'(q_if.pop_accept) > pc) ? pc : int'(q_if.pop_accept);
        ready = (mq.size() != 16) && !flush;
        if (flush) begin
            model_clear();
        end else begin
`ifdef IIQ_STATS_EN
            m_bundles += int'(q_if.push_valid && ready);
            m_issued  += a;
            m_stalls  += int'(q_if.push_valid && !ready);
`endif
            if (a > 0) begin
                m_off += a;
                if (m_off == mq[0].copies) begin
                    void'(mq.pop_front());
                    m_off = 0;
                end
            end
            if (q_if.push_valid && ready) begin
                cp = int'(q_if.push_copies);
                if (cp == 0) cp = 1;
                if (cp > 8) cp = 8;
                b.instr = q_if.push_instr; b.copies = cp;
                b.ca = int'(q_if.push_cache_addr); b.cs = int'(q_if.push_cache_stride);
                b.mm = int'(q_if.push_main_mem_addr);
                mq.push_back(b);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic [3:0] cp,
                        input logic [17:0] ca, input logic [17:0] cs, input logic [17:0] mm,
                        input logic [1:0] acc, input logic fl);
        drive(v, ins, cp, ca, cs, mm, acc, fl);
        #1;
        compare_model();
        advance();
    endtask

    task automatic do_flush();
        step(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd0, 1'b1);
    endtask

    initial begin
        // Scenario 1 expectations, written out by hand.
        tbl[0] = '{1'b1, 4'd8, 18'd100, 18'd4, 2'd0, 2'd0, 54'd0, 5'd0};
        tbl[1] = '{1'b0, 4'd0, 18'd0, 18'd0, 2'd3, 2'd3, {18'd108, 18'd104, 18'd100}, 5'd1};
        tbl[2] = '{1'b0, 4'd0, 18'd0, 18'd0, 2'd3, 2'd3, {18'd120, 18'd116, 18'd112}, 5'd1};
        tbl[3] = '{1'b0, 4'd0, 18'd0, 18'd0, 2'd2, 2'd2, {18'd0, 18'd128, 18'd124}, 5'd1};
        tbl[4] = '{1'b0, 4'd0, 18'd0, 18'd0, 2'd0, 2'd0, 54'd0, 5'd0};

        reset_n = 1'b0;
        drive(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd0, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_pop_count", 64'(q_if.pop_count), 64'd0);
        check("reset_push_ready", 64'(q_if.push_ready), 64'd1);
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_pop_cache", 64'(q_if.pop_cache_addr), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].v, 16'hC123, tbl[i].cp, tbl[i].ca, tbl[i].cs, 18'd7, tbl[i].acc, 1'b0);
            #1;
            check($sformatf("tbl%0d_pop_count", i), 64'(q_if.pop_count), 64'(tbl[i].e_pc));
            check($sformatf("tbl%0d_cache", i), 64'(q_if.pop_cache_addr), 64'(tbl[i].e_cache));
            check($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
            compare_model();
            advance();
        end
`ifdef IIQ_STATS_EN
        check("s1_stat_bundles", 64'(stat_bundles), 64'd1);
        check("s1_stat_issued", 64'(stat_issued), 64'd8);
        check("s1_stat_stalls", 64'(stat_push_stalls), 64'd0);
`endif

        // Fill to 16 with no consumption.
        do_flush();
        for (int i = 0; i < 16; i++)
            step(1'b1, 16'(i), 4'd2, 18'(i * 10), 18'd1, 18'd5, 2'd0, 1'b0);
        drive(1'b1, 16'hBEEF, 4'd2, 18'd0, 18'd1, 18'd0, 2'd0, 1'b0);
        #1;
        check("full_push_ready", 64'(q_if.push_ready), 64'd0);
        check("full_occupancy", 64'(occupancy), 64'd16);
        compare_model();
        advance();
        check("full_17th_rejected", 64'(occupancy), 64'd16);
        step(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd2, 1'b0);   // retire -> 15
        drive(1'b1, 16'hAAAA, 4'd3, 18'd0, 18'd1, 18'd0, 2'd2, 1'b0);
        #1;
        check("pre_pushretire_occ", 64'(occupancy), 64'd15);
        compare_model();
        advance();
        check("pushretire_occ", 64'(occupancy), 64'd15);

        // No spanning of two bundles in one cycle.
        do_flush();
        step(1'b1, 16'h1111, 4'd2, 18'd10, 18'd1, 18'd0, 2'd0, 1'b0);
        step(1'b1, 16'h2222, 4'd1, 18'd50, 18'd1, 18'd0, 2'd0, 1'b0);
        drive(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd3, 1'b0);
        #1;
        check("span_first", 64'(q_if.pop_count), 64'd2);
        advance();
        #1;
        check("span_second", 64'(q_if.pop_count), 64'd1);
        advance();

        // Copy count clamping and stride wraparound.
        do_flush();
        step(1'b1, 16'h3333, 4'd0, 18'd0, 18'd1, 18'd0, 2'd0, 1'b0);
        step(1'b1, 16'h4444, 4'd15, 18'd0, 18'd2, 18'd0, 2'd0, 1'b0);
        drive(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd3, 1'b0);
        #1;
        check("copies0_count", 64'(q_if.pop_count), 64'd1);
        advance();
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd3, 1'b0);
        check("copies15_drained", 64'(occupancy), 64'd0);
        step(1'b1, 16'h5555, 4'd3, 18'd0, 18'h3FFFF, 18'd9, 2'd0, 1'b0);
        drive(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd3, 1'b0);
        #1;
        check("stride_wrap", 64'(q_if.pop_cache_addr), 64'({18'h3FFFE, 18'h3FFFF, 18'h00000}));
        advance();

        // Flush mid-expansion beats a concurrent push.
        do_flush();
        step(1'b1, 16'hC123, 4'd8, 18'd100, 18'd4, 18'd7, 2'd0, 1'b0);
        step(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd3, 1'b0);
        drive(1'b1, 16'h7777, 4'd2, 18'd0, 18'd1, 18'd0, 2'd3, 1'b1);
        #1;
        check("flush_push_ready", 64'(q_if.push_ready), 64'd0);
        advance();
        drive(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd0, 1'b0);
        #1;
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_pop_count", 64'(q_if.pop_count), 64'd0);
        advance();

        // Asynchronous reset mid-expansion.
        step(1'b1, 16'hC123, 4'd8, 18'd100, 18'd4, 18'd7, 2'd0, 1'b0);
        step(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd3, 1'b0);
        drive(1'b1, 16'h8888, 4'd2, 18'd0, 18'd1, 18'd0, 2'd3, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_pop_count", 64'(q_if.pop_count), 64'd0);
        check("rst_async_occ", 64'(occupancy), 64'd0);
        check("rst_async_cache", 64'(q_if.pop_cache_addr), 64'd0);
        check("rst_async_instr", 64'(q_if.pop_instr), 64'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 16'h0, 4'd0, 18'd0, 18'd0, 18'd0, 2'd0, 1'b0);

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 16'($urandom), 4'($urandom_range(0, 15)),
                 18'($urandom), 18'($urandom), 18'($urandom),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
